// File: rtl/alarm_annunciator_pkg.sv
// Shared constants and types for the alarm annunciator: channel map, FSM states,
// and counter sizing helper.
package alarm_annunciator_pkg;

  localparam int CH_CTRAL = 0;
  localparam int CH_PIPAL = 1;
  localparam int CH_SCAFL = 2;
  localparam int CH_TCAL  = 3;
  localparam int CH_VFAIL = 4;
  localparam int CH_WARNF = 5;
  localparam int CH_RPTAL = 6;
  localparam int CH_OSCAL = 7;

  // Auxiliary inputs sit above the alarm channels in the debounce bank
  localparam int NUM_AUX    = 3;
  localparam int AUX_RESTRT = 0;
  localparam int AUX_CGCWAR = 1;
  localparam int AUX_RSETKY = 2;

  localparam int WAIT_CNT_MIN_W = 8;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, CLEAR} ann_state_t;

  function automatic int cnt_width(input int max_val, input int min_w);
    int w;
    w = $clog2(max_val + 1);
    if (w < min_w) w = min_w;
    return w;
  endfunction

endpackage

// File: rtl/alarm_debounce.sv
// Two-flop synchroniser followed by a saturating run-length debouncer; dout is
// high while DEB_LEN consecutive active samples have been seen.
module alarm_debounce #(
  parameter int DEB_LEN = 4
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(DEB_LEN);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (!s2)              cnt <= '0;
      else if (cnt != FULL) cnt <= cnt + 1'b1;
    end
  end

  assign dout = (cnt == FULL);

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: debounces alarm/restart/warning/key inputs, latches sticky
// alarms, drives lamps and runs the ERRST pulse-then-wait reset sequence.
// Optional first-fault capture is built when ANNUN_FIRST_FAULT_EN is defined.
module alarm_annunciator
  import alarm_annunciator_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int DEB_LEN   = 4,
  parameter int ERRST_LEN = 8,
  parameter int WAIT_MAX  = 255
) (
  input  logic           CLOCK,
  input  logic           rst,
  input  logic [NCH-1:0] ALM_,
  input  logic           RESTRT,
  input  logic           CGCWAR,
  input  logic           FLASH,
  input  logic           RSETKY,
  output logic           ERRST,
  output logic [NCH-1:0] LAMP,
  output logic           RSTLMP,
  output logic           CAUTN,
  output logic [NCH-1:0] ALMREG,
  output logic           BUSY
`ifdef ANNUN_FIRST_FAULT_EN
  ,
  output logic                    FFVLD,
  output logic [$clog2(NCH)-1:0]  FFIDX
`endif
);

  localparam int NIN = NCH + NUM_AUX;
  localparam int PCW = cnt_width(ERRST_LEN - 1, 1);
  localparam int WCW = cnt_width(WAIT_MAX, WAIT_CNT_MIN_W);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(ERRST_LEN - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_MAX - 1);

  logic [NIN-1:0] raw, deb;
  logic [NCH-1:0] alm_act, almreg_nxt;
  logic           rst_act, cgc_act, key_act, key_q, key_rise, quiet, clr;
  logic           rstlmp_nxt;

  assign raw = {RSETKY, CGCWAR, RESTRT, ~ALM_};

  for (genvar i = 0; i < NIN; i++) begin : g_deb
    alarm_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
      .CLOCK (CLOCK),
      .rst   (rst),
      .din   (raw[i]),
      .dout  (deb[i])
    );
  end

  assign alm_act  = deb[NCH-1:0];
  assign rst_act  = deb[NCH+AUX_RESTRT];
  assign cgc_act  = deb[NCH+AUX_CGCWAR];
  assign key_act  = deb[NCH+AUX_RSETKY];
  assign key_rise = key_act & ~key_q;
  assign quiet    = ~(|alm_act | rst_act);

  ann_state_t     state, state_nxt;
  logic [PCW-1:0] pcnt, pcnt_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pcnt  <= '0;
      wcnt  <= '0;
      key_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
      wcnt  <= wcnt_nxt;
      key_q <= key_act;
    end
  end

  // Key edges outside IDLE fall through untouched, so they are simply dropped
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: if (key_rise) begin
        state_nxt = PULSE;
        pcnt_nxt  = '0;
      end
      PULSE: if (pcnt == PULSE_LAST) begin
        wcnt_nxt  = '0;
        state_nxt = (WAIT_MAX == 0) ? CLEAR : WAIT;
      end else begin
        pcnt_nxt = pcnt + 1'b1;
      end
      WAIT: if (quiet || wcnt == WAIT_LAST) state_nxt = CLEAR;
            else wcnt_nxt = wcnt + 1'b1;
      CLEAR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A bit being set on the same edge as CLEAR survives (set over clear)
  assign clr        = (state == CLEAR);
  assign almreg_nxt = (clr ? (ALMREG & alm_act) : ALMREG) | alm_act;
  assign rstlmp_nxt = (clr ? (RSTLMP & rst_act) : RSTLMP) | rst_act;

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      ALMREG <= '0;
      RSTLMP <= 1'b0;
    end else begin
      ALMREG <= almreg_nxt;
      RSTLMP <= rstlmp_nxt;
    end
  end

  assign ERRST = (state == PULSE);
  assign BUSY  = (state != IDLE);
  assign LAMP  = ALMREG & {NCH{FLASH}};
  assign CAUTN = (|ALMREG) | RSTLMP | cgc_act;

`ifdef ANNUN_FIRST_FAULT_EN
  localparam int FFW = $clog2(NCH);
  logic [FFW-1:0] low_idx;

  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (almreg_nxt[i]) low_idx = FFW'(i);
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      FFVLD <= 1'b0;
      FFIDX <= '0;
    end else if (ALMREG == '0 && almreg_nxt != '0) begin
      FFVLD <= 1'b1;
      FFIDX <= low_idx;
    end else if (almreg_nxt == '0) begin
      FFVLD <= 1'b0;
      FFIDX <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_alarm_annunciator.sv
// Self-checking bench for alarm_annunciator: vector table, hand sequences for the
// reset-key / timeout / mid-pulse reset cases, and random stimulus vs. a model.
module tb_alarm_annunciator;

  localparam int NCH       = 8;
  localparam int DEB_LEN   = 4;
  localparam int ERRST_LEN = 8;
  localparam int WAIT_MAX  = 255;
  localparam logic [10:0] A1  = 11'h002;
  localparam logic [10:0] A2  = 11'h004;
  localparam logic [10:0] A3  = 11'h008;
  localparam logic [10:0] A5  = 11'h020;
  localparam logic [10:0] A6  = 11'h040;
  localparam logic [10:0] RS  = 11'h100;
  localparam logic [10:0] CG  = 11'h200;
  localparam logic [10:0] KEY = 11'h400;

  logic       CLOCK = 1'b0;
  logic       rst   = 1'b0;
  logic [7:0] ALM_  = 8'hFF;
  logic       RESTRT = 1'b0, CGCWAR = 1'b0, FLASH = 1'b0, RSETKY = 1'b0;
  logic       ERRST, RSTLMP, CAUTN, BUSY;
  logic [7:0] LAMP, ALMREG;
`ifdef ANNUN_FIRST_FAULT_EN
  logic       FFVLD;
  logic [2:0] FFIDX;
`endif

  always #5 CLOCK = ~CLOCK;

  alarm_annunciator #(
    .NCH(NCH), .DEB_LEN(DEB_LEN), .ERRST_LEN(ERRST_LEN), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .CLOCK(CLOCK), .rst(rst), .ALM_(ALM_), .RESTRT(RESTRT), .CGCWAR(CGCWAR),
    .FLASH(FLASH), .RSETKY(RSETKY), .ERRST(ERRST), .LAMP(LAMP), .RSTLMP(RSTLMP),
    .CAUTN(CAUTN), .ALMREG(ALMREG), .BUSY(BUSY)
`ifdef ANNUN_FIRST_FAULT_EN
    , .FFVLD(FFVLD), .FFIDX(FFIDX)
`endif
  );

  int n_pass = 0, n_total = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: inputs as active-high vector {key, cgc, restrt, alm[7:0]}.
  // An input counts as accepted once it was sampled active DEB_LEN times in a row,
  // two samples back (synchroniser delay).
  int         run0 [11], run1 [11], run2 [11];
  logic [10:0] deb, deb_d;
  logic [7:0] m_alm;
  logic       m_rst, m_busy, m_clr, cur_flash;
  int         m_t;
`ifdef ANNUN_FIRST_FAULT_EN
  logic       m_ffv;
  logic [2:0] m_ffi;
`endif

  task automatic model_reset();
    for (int i = 0; i < 11; i++) begin run0[i] = 0; run1[i] = 0; run2[i] = 0; end
    deb = '0; deb_d = '0; m_alm = '0; m_rst = 0; m_busy = 0; m_clr = 0; m_t = 0;
`ifdef ANNUN_FIRST_FAULT_EN
    m_ffv = 0; m_ffi = '0;
`endif
  endtask

  task automatic model_edge(input logic [10:0] a);
    logic       kr, qt;
    logic [7:0] prev;
    int         w;
    kr   = deb[10] & ~deb_d[10];
    qt   = (deb[8:0] == 9'd0);
    prev = m_alm;
    if (m_clr) begin
      m_alm = (m_alm & deb[7:0]) | deb[7:0];
      m_rst = (m_rst & deb[8]) | deb[8];
    end else begin
      m_alm = m_alm | deb[7:0];
      m_rst = m_rst | deb[8];
    end
`ifdef ANNUN_FIRST_FAULT_EN
    if (prev == 0 && m_alm != 0) begin
      m_ffv = 1;
      for (int i = 7; i >= 0; i--) if (m_alm[i]) m_ffi = 3'(i);
    end else if (m_alm == 0) begin
      m_ffv = 0; m_ffi = '0;
    end
`else
    if (prev == 8'hxx) m_alm = m_alm;
`endif
    // m_t: cycles since the sequence started; pulse occupies the first ERRST_LEN
    if (m_clr) begin
      m_clr = 0; m_busy = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t >= ERRST_LEN) begin
        w = m_t - ERRST_LEN;
        if (w == 0) begin
          if (WAIT_MAX == 0) m_clr = 1;
        end else if (qt || w >= WAIT_MAX) m_clr = 1;
      end
    end else if (kr) begin
      m_busy = 1; m_t = 0;
    end
    deb_d = deb;
    for (int i = 0; i < 11; i++) begin
      run2[i] = run1[i];
      run1[i] = run0[i];
      run0[i] = a[i] ? run0[i] + 1 : 0;
      deb[i]  = (run2[i] >= DEB_LEN);
    end
  endtask

  task automatic check_model();
    chk($sformatf("almreg c%0d", cyc), ALMREG, m_alm);
    chk($sformatf("rstlmp c%0d", cyc), RSTLMP, m_rst);
    chk($sformatf("cautn c%0d", cyc), CAUTN, (|m_alm) | m_rst | deb[9]);
    chk($sformatf("lamp c%0d", cyc), LAMP, m_alm & {8{cur_flash}});
    chk($sformatf("errst c%0d", cyc), ERRST, m_busy && !m_clr && (m_t < ERRST_LEN));
    chk($sformatf("busy c%0d", cyc), BUSY, m_busy);
`ifdef ANNUN_FIRST_FAULT_EN
    chk($sformatf("ffvld c%0d", cyc), FFVLD, m_ffv);
    chk($sformatf("ffidx c%0d", cyc), FFIDX, m_ffi);
`endif
  endtask

  task automatic drive(input logic [10:0] a, input logic f);
    ALM_ = ~a[7:0]; RESTRT = a[8]; CGCWAR = a[9]; RSETKY = a[10]; FLASH = f;
    cur_flash = f;
  endtask

  task automatic step(input logic [10:0] a, input logic f);
    drive(a, f);
    @(posedge CLOCK);
    model_edge(a);
    @(negedge CLOCK);
    cyc++;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " errst"}, ERRST, 0);
    chk({tag, " busy"}, BUSY, 0);
    chk({tag, " almreg"}, ALMREG, 0);
    chk({tag, " lamp"}, LAMP, 0);
    chk({tag, " rstlmp"}, RSTLMP, 0);
    chk({tag, " cautn"}, CAUTN, 0);
  endtask

  typedef struct {
    logic [10:0] act;
    logic        flash;
    int          n;
    logic [7:0]  almreg;
    logic [7:0]  lamp;
    logic        cautn;
    logic        busy;
    logic        errst;
  } vec_t;

  vec_t tbl [12];
  int   busy_n, errst_n, busy_rise, errst_rise;
  logic pb, pe;
  logic [10:0] ra;

  initial begin
    tbl[0]  = '{11'h0, 1'b0, 4,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{A2,    1'b0, 3,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{11'h0, 1'b0, 6,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{A2,    1'b1, 6,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{A2,    1'b1, 1,  8'h04, 8'h04, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{11'h0, 1'b0, 10, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{KEY,   1'b1, 6,  8'h04, 8'h04, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{KEY,   1'b1, 1,  8'h04, 8'h04, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{11'h0, 1'b0, 7,  8'h04, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{11'h0, 1'b0, 1,  8'h04, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{11'h0, 1'b0, 1,  8'h04, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{11'h0, 1'b0, 1,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

    model_reset();
    drive('0, 1'b0);
    repeat (3) @(negedge CLOCK);
    check_all_zero("reset");
    rst = 1'b1;

    // Glitch rejection, latch latency, lamp flash, full reset-key clear
    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].n) step(tbl[i].act, tbl[i].flash);
      chk($sformatf("v%0d almreg", i), ALMREG, tbl[i].almreg);
      chk($sformatf("v%0d lamp", i),   LAMP,   tbl[i].lamp);
      chk($sformatf("v%0d cautn", i),  CAUTN,  tbl[i].cautn);
      chk($sformatf("v%0d busy", i),   BUSY,   tbl[i].busy);
      chk($sformatf("v%0d errst", i),  ERRST,  tbl[i].errst);
    end

    // Alarm held through the key sequence: WAIT must time out, alarm retained
    repeat (8) step(A5, 1'b0);
    busy_n = 0; errst_n = 0;
    for (int i = 0; i < 407; i++) begin
      step((i < 7) ? (A5 | KEY) : A5, 1'b0);
      if (BUSY) busy_n++;
      if (ERRST) errst_n++;
    end
    chk("timeout busy_cycles", busy_n, ERRST_LEN + WAIT_MAX + 1);
    chk("timeout errst_cycles", errst_n, ERRST_LEN);
    chk("timeout almreg", ALMREG, 8'h20);
    repeat (10) step('0, 1'b1);
    chk("sticky almreg", ALMREG, 8'h20);
    repeat (7) step(KEY, 1'b0);
    repeat (20) step('0, 1'b0);
    chk("cleared almreg", ALMREG, 8'h00);

    // Second key press during PULSE is dropped
    busy_n = 0; errst_n = 0; busy_rise = 0; errst_rise = 0; pb = 0; pe = 0;
    for (int i = 0; i < 48; i++) begin
      step((i < 7 || (i >= 8 && i < 28)) ? KEY : 11'h0, 1'b0);
      if (BUSY && !pb) busy_rise++;
      if (ERRST && !pe) errst_rise++;
      if (ERRST) errst_n++;
      pb = BUSY; pe = ERRST;
    end
    chk("rekey errst_pulses", errst_rise, 1);
    chk("rekey busy_starts", busy_rise, 1);
    chk("rekey errst_cycles", errst_n, ERRST_LEN);

    // Restart / warning latch, then async reset mid-PULSE
    repeat (8) step(A3 | RS | CG, 1'b1);
    chk("restrt rstlmp", RSTLMP, 1);
    chk("restrt almreg", ALMREG, 8'h08);
    chk("restrt lamp", LAMP, 8'h08);
    repeat (7) step(A3 | RS | CG | KEY, 1'b1);
    repeat (3) step(A3 | RS | CG, 1'b1);
    chk("midpulse errst_before", ERRST, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("async");
    model_reset();
    drive('0, 1'b0);
    @(negedge CLOCK);
    rst = 1'b1;
    repeat (4) step('0, 1'b0);

`ifdef ANNUN_FIRST_FAULT_EN
    repeat (8) step(A6, 1'b0);
    repeat (8) step(A6 | A1, 1'b0);
    chk("ff idx6", FFIDX, 6);
    chk("ff vld", FFVLD, 1);
    repeat (8) step('0, 1'b0);
    repeat (7) step(KEY, 1'b0);
    repeat (20) step('0, 1'b0);
    chk("ff cleared", FFVLD, 0);
    repeat (8) step(A3 | A5, 1'b0);
    chk("ff same_edge idx", FFIDX, 3);
    repeat (8) step('0, 1'b0);
    repeat (7) step(KEY, 1'b0);
    repeat (20) step('0, 1'b0);
`endif

    // Random stimulus: alarms lean toward releasing so some sequences end early
    ra = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 11; b++) begin
        if (ra[b]) begin
          if ($urandom_range(0, 5) == 0) ra[b] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) ra[b] = 1'b1;
      end
      step(ra, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
